game_input_ctrl: RTL and testbench

GAME_INPUT_CTRL -- requirements
Module: game_input_ctrl

---
 rtl/game_input_ctrl.sv | 165 ++++++++++++++++
 tb/tb_game_input_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_input_ctrl.sv
// Game input controller: synchronizes and debounces four raw buttons, turns the
// new-game button into a single request pulse, and generates a frame strobe with
// frame and overrun bookkeeping against the gameplay engine's acknowledge.
module game_input_ctrl #(
    parameter int unsigned FRAME_CYCLES    = 1666667,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        btn_new_game,
    input  logic        btn_hit,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        out_ready,
    output logic        new_game,
    output logic        charging_hit,
    output logic        camera_pan_left,
    output logic        camera_pan_right,
    output logic        new_frame,
    output logic [15:0] frame_count,
    output logic [7:0]  overrun_count
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned FR_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FR_W-1:0] FR_MAX = FR_W'(FRAME_CYCLES - 1);

    // Button lane indices
    localparam int unsigned BTN_NG    = 0;
    localparam int unsigned BTN_HIT   = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    logic [3:0]            btn_raw;
    logic [3:0]            sync1_q, sync2_q;
    logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]            acc_q, acc_d;
    logic                  ng_prev_q;

    logic [FR_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic                  pending_q, pending_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic [7:0]            overrun_q, overrun_d;

    logic                  new_game_q, new_game_d;
    logic                  new_frame_q, new_frame_d;
    logic                  charging_hit_q, charging_hit_d;
    logic                  pan_left_q, pan_left_d;
    logic                  pan_right_q, pan_right_d;

    logic                  ng_rise;
    logic                  wrap;

    assign btn_raw = {btn_right, btn_left, btn_hit, btn_new_game};

    // Two-flop synchronizers; nothing downstream looks at the raw pins.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-button debounce: count while synchronized level disagrees with accepted level.
    always_comb begin
        acc_d    = acc_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != acc_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    acc_d[i] = ~acc_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Debounce state and previous accepted new-game level for edge detection.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            db_cnt_q  <= '0;
            acc_q     <= '0;
            ng_prev_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            acc_q     <= acc_d;
            ng_prev_q <= acc_q[BTN_NG];
        end
    end

    assign ng_rise = acc_q[BTN_NG] & ~ng_prev_q;
    assign wrap    = (frame_cnt_q == FR_MAX);

    // Frame timing, frame/overrun bookkeeping and registered output next-state.
    always_comb begin
        new_game_d     = ng_rise;
        new_frame_d    = wrap & ~ng_rise;
        charging_hit_d = acc_q[BTN_HIT];
        // Opposing pan requests cancel each other.
        pan_left_d     = acc_q[BTN_LEFT] & ~acc_q[BTN_RIGHT];
        pan_right_d    = acc_q[BTN_RIGHT] & ~acc_q[BTN_LEFT];

        frame_cnt_d    = wrap ? '0 : frame_cnt_q + FR_W'(1);
        frame_count_d  = wrap ? frame_count_q + 16'd1 : frame_count_q;
        pending_d      = pending_q;
        overrun_d      = overrun_q;

        if (new_frame_q) begin
            // A same-cycle out_ready acknowledges the previous frame, not this one.
            if (pending_q && !out_ready && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
            pending_d = 1'b1;
        end else if (out_ready) begin
            pending_d = 1'b0;
        end

        // A new game restarts the whole frame timeline and wins over a wrap.
        if (ng_rise) begin
            frame_cnt_d   = '0;
            frame_count_d = '0;
            pending_d     = 1'b0;
            overrun_d     = '0;
        end
    end

    // Frame state and all output registers.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            frame_cnt_q    <= '0;
            pending_q      <= 1'b0;
            frame_count_q  <= '0;
            overrun_q      <= '0;
            new_game_q     <= 1'b0;
            new_frame_q    <= 1'b0;
            charging_hit_q <= 1'b0;
            pan_left_q     <= 1'b0;
            pan_right_q    <= 1'b0;
        end else begin
            frame_cnt_q    <= frame_cnt_d;
            pending_q      <= pending_d;
            frame_count_q  <= frame_count_d;
            overrun_q      <= overrun_d;
            new_game_q     <= new_game_d;
            new_frame_q    <= new_frame_d;
            charging_hit_q <= charging_hit_d;
            pan_left_q     <= pan_left_d;
            pan_right_q    <= pan_right_d;
        end
    end

    assign new_game         = new_game_q;
    assign new_frame        = new_frame_q;
    assign charging_hit     = charging_hit_q;
    assign camera_pan_left  = pan_left_q;
    assign camera_pan_right = pan_right_q;
    assign frame_count      = frame_count_q;
    assign overrun_count    = overrun_q;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed bench for game_input_ctrl with FRAME_CYCLES=20, DEBOUNCE_CYCLES=4.
module tb_game_input_ctrl;

    localparam int unsigned FC = 20;
    localparam int unsigned DC = 4;

    logic        clk_in = 1'b0;
    logic        rst_in_n = 1'b0;
    logic        btn_new_game = 1'b0;
    logic        btn_hit = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        out_ready = 1'b0;
    logic        new_game;
    logic        charging_hit;
    logic        camera_pan_left;
    logic        camera_pan_right;
    logic        new_frame;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    game_input_ctrl #(
        .FRAME_CYCLES   (FC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk_in          (clk_in),
        .rst_in_n        (rst_in_n),
        .btn_new_game    (btn_new_game),
        .btn_hit         (btn_hit),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .out_ready       (out_ready),
        .new_game        (new_game),
        .charging_hit    (charging_hit),
        .camera_pan_left (camera_pan_left),
        .camera_pan_right(camera_pan_right),
        .new_frame       (new_frame),
        .frame_count     (frame_count),
        .overrun_count   (overrun_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_in_n     = 1'b0;
        btn_new_game = 1'b0;
        btn_hit      = 1'b0;
        btn_left     = 1'b0;
        btn_right    = 1'b0;
        out_ready    = 1'b0;
        step(3);
        rst_in_n = 1'b1;
    endtask

    // Press hit for 'hold' edges; report edges (from press) of output rise and fall.
    task automatic measure_hit(input int hold, output int rise, output int fall);
        rise = -1;
        fall = -1;
        btn_hit = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (i == hold + 1) btn_hit = 1'b0;
            step(1);
            if (charging_hit && rise < 0) rise = i;
            if (!charging_hit && rise >= 0 && fall < 0) fall = i;
        end
        btn_hit = 1'b0;
    endtask

    initial begin
        int nf_cnt;
        int nf_bad;
        int nf_first;
        int last_nf;
        int ng_cnt;
        int ng_first;
        int hi;
        int rise;
        int fall;

        // Reset state
        step(2);
        check("rst_new_game", 32'(new_game), 0);
        check("rst_new_frame", 32'(new_frame), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_overrun", 32'(overrun_count), 0);
        check("rst_charging_hit", 32'(charging_hit), 0);
        check("rst_pan_left", 32'(camera_pan_left), 0);
        check("rst_pan_right", 32'(camera_pan_right), 0);
        rst_in_n = 1'b1;

        // Free run 100 edges, acknowledging 2 cycles after each strobe
        nf_cnt = 0; nf_bad = 0; nf_first = -1; last_nf = -10;
        for (int e = 1; e <= 100; e++) begin
            step(1);
            if (new_frame) begin
                nf_cnt++;
                last_nf = e;
                if (nf_first < 0) nf_first = e;
                if (e % 20 != 0) nf_bad++;
            end
            out_ready = (e == last_nf + 2);
        end
        out_ready = 1'b0;
        check("run_first_frame_edge", nf_first, 20);
        check("run_frame_pulses", nf_cnt, 5);
        check("run_misplaced_frames", nf_bad, 0);
        check("run_frame_count", 32'(frame_count), 5);
        check("run_overrun", 32'(overrun_count), 0);

        // No acknowledges: overruns accumulate then saturate
        do_reset();
        step(121);
        check("ovr_6frames", 32'(overrun_count), 5);
        check("ovr_6frames_count", 32'(frame_count), 6);
        step(255 * 20 + 1 - 121);
        check("ovr_255frames", 32'(overrun_count), 254);
        step(20);
        check("ovr_256frames", 32'(overrun_count), 255);
        step(44 * 20);
        check("ovr_300frames_sat", 32'(overrun_count), 255);
        check("ovr_300frames_count", 32'(frame_count), 300);

        // out_ready coinciding with new_frame
        do_reset();
        step(20);
        check("coin_frame1", 32'(new_frame), 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(19);
        check("coin_frame2", 32'(new_frame), 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("coin_no_overrun", 32'(overrun_count), 0);
        step(20);
        check("coin_pending_kept", 32'(overrun_count), 1);

        // new_game pulse landing on the wrap cycle
        do_reset();
        step(13);
        btn_new_game = 1'b1;
        step(7);
        check("wrap_new_game", 32'(new_game), 1);
        check("wrap_new_frame_blocked", 32'(new_frame), 0);
        nf_first = -1;
        for (int i = 1; i <= 25; i++) begin
            step(1);
            if (new_frame && nf_first < 0) nf_first = i;
        end
        btn_new_game = 1'b0;
        check("wrap_next_frame", nf_first, 20);

        // Held new_game: one pulse, clears frame state
        do_reset();
        step(61);
        check("ng_pre_overrun", 32'(overrun_count), 2);
        check("ng_pre_frame_count", 32'(frame_count), 3);
        btn_new_game = 1'b1;
        ng_cnt = 0; ng_first = -1; nf_first = -1;
        for (int i = 1; i <= 50; i++) begin
            step(1);
            if (new_game) begin
                ng_cnt++;
                if (ng_first < 0) ng_first = i;
            end
            if (new_frame && nf_first < 0) nf_first = i;
            if (i == 7) begin
                check("ng_clear_frame_count", 32'(frame_count), 0);
                check("ng_clear_overrun", 32'(overrun_count), 0);
            end
        end
        check("ng_pulse_count", ng_cnt, 1);
        check("ng_pulse_edge", ng_first, 7);
        check("ng_next_frame", nf_first, 27);
        check("ng_post_frame_count", 32'(frame_count), 2);
        check("ng_post_overrun", 32'(overrun_count), 1);
        btn_new_game = 1'b0;
        ng_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (new_game) ng_cnt++;
        end
        check("ng_no_release_pulse", ng_cnt, 0);

        // Hit debounce: glitch, exact threshold, long hold
        do_reset();
        step(2);
        hi = 0;
        btn_hit = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            if (i == 4) btn_hit = 1'b0;
            step(1);
            if (charging_hit) hi++;
        end
        check("hit_glitch3", hi, 0);
        measure_hit(4, rise, fall);
        check("hit4_rise", rise, 7);
        check("hit4_fall", fall, 11);
        measure_hit(10, rise, fall);
        check("hit10_rise", rise, 7);
        check("hit10_fall", fall, 17);

        // Pan: both held cancel, single direction follows
        do_reset();
        step(2);
        btn_left = 1'b1;
        btn_right = 1'b1;
        hi = 0;
        for (int i = 1; i <= 15; i++) begin
            step(1);
            if (camera_pan_left || camera_pan_right) hi++;
        end
        check("pan_both_cancel", hi, 0);
        btn_right = 1'b0;
        step(8);
        check("pan_left_only", 32'(camera_pan_left), 1);
        check("pan_right_off", 32'(camera_pan_right), 0);

        // Reset asserted mid-frame with outputs active
        btn_hit = 1'b1;
        step(30);
        check("mid_pre_hit", 32'(charging_hit), 1);
        #3;
        rst_in_n = 1'b0;
        btn_hit = 1'b0;
        btn_left = 1'b0;
        #1;
        check("mid_rst_hit", 32'(charging_hit), 0);
        check("mid_rst_pan", 32'(camera_pan_left), 0);
        check("mid_rst_frame_count", 32'(frame_count), 0);
        check("mid_rst_all", 32'({new_game, new_frame, charging_hit, camera_pan_left,
                                  camera_pan_right, frame_count, overrun_count}), 0);
        step(2);
        rst_in_n = 1'b1;
        nf_first = -1;
        for (int i = 1; i <= 25; i++) begin
            step(1);
            if (new_frame && nf_first < 0) nf_first = i;
        end
        check("mid_first_frame", nf_first, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
